// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline.
// Latency: forward/stall/flush outputs are combinational from inputs and the shadow scoreboard.
// Backpressure: a pending data-memory access (mem_req_M && !mem_ready_M) freezes F/D/E/M and bubbles W.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   Rs1_D, Rs2_D                  Decode-stage source registers (load-use detection)
//   Rs1_E, Rs2_E, Rd_E            Execute-stage sources / destination
//   RegWrite_E, ResultSrc_E0      Execute instruction writes Rd / is a load
//   PCSrc_E                       taken branch or jump resolved in Execute
//   mem_req_M, mem_ready_M        Memory-stage access in progress / completing
//   ForwardA_E, ForwardB_E        SrcA/SrcB select: 00 RD_E, 01 Result_W, 10 ALUResult_M
//   Stall_F/D/E/M                 hold enables for PC and pipeline registers
//   Flush_D/E/W                   clear enables for IF/ID, ID/EX, MEM/WB
//   mem_timeout                   sticky flag: memory wait reached MAX_WAIT cycles
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_events counters.

module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1_D,
    input  logic [REG_W-1:0] Rs2_D,
    input  logic [REG_W-1:0] Rs1_E,
    input  logic [REG_W-1:0] Rs2_E,
    input  logic [REG_W-1:0] Rd_E,
    input  logic             RegWrite_E,
    input  logic             ResultSrc_E0,
    input  logic             PCSrc_E,
    input  logic             mem_req_M,
    input  logic             mem_ready_M,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_timeout;

    // Shadow scoreboard of destination/write-enable for M and W stages.
    logic [REG_W-1:0] r_rd_m;
    logic             r_rw_m;
    logic [REG_W-1:0] r_rd_w;
    logic             r_rw_w;

    logic             w_mem_stall;
    logic             w_load_use;

    assign w_mem_stall = mem_req_M & ~mem_ready_M;
    assign w_load_use  = ResultSrc_E0 & RegWrite_E & (Rd_E != '0) &
                         ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));

    // Forwarding: M stage wins over W; x0 is never forwarded.
    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (!rst) begin
            if (r_rw_m && (r_rd_m != '0) && (r_rd_m == Rs1_E))
                ForwardA_E = 2'b10;
            else if (r_rw_w && (r_rd_w != '0) && (r_rd_w == Rs1_E))
                ForwardA_E = 2'b01;

            if (r_rw_m && (r_rd_m != '0) && (r_rd_m == Rs2_E))
                ForwardB_E = 2'b10;
            else if (r_rw_w && (r_rd_w != '0) && (r_rd_w == Rs2_E))
                ForwardB_E = 2'b01;
        end
    end

    // Stall/flush priority: memory wait > taken branch > load-use.
    // A branch held in E by a memory wait keeps PCSrc_E asserted, so its
    // flush lands naturally in the first cycle the wait lifts.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_W = 1'b0;
        if (!rst) begin
            if (w_mem_stall) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
                Flush_W = 1'b1;
            end else if (PCSrc_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (w_load_use) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
        end
    end

    // Shadow scoreboard. Flush_E only bubbles ID/EX; the instruction already
    // in E still advances into M, so its capture ignores Flush_E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_m <= '0;
            r_rw_m <= 1'b0;
            r_rd_w <= '0;
            r_rw_w <= 1'b0;
        end else begin
            if (!Stall_M) begin
                r_rd_m <= Rd_E;
                r_rw_m <= RegWrite_E;
            end
            if (Flush_W) begin
                r_rd_w <= '0;
                r_rw_w <= 1'b0;
            end else begin
                r_rd_w <= r_rd_m;
                r_rw_w <= r_rw_m;
            end
        end
    end

    // Memory-wait FSM: wait_cnt counts completed stalled cycles, saturating.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            S_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait_cnt != 8'hFF)
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end else begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            // Flag on the edge the count reaches the limit; stays set until reset.
            if ((w_state_nxt == S_WAIT) && (w_wait_cnt_nxt >= LP_MAX_WAIT))
                r_timeout <= 1'b1;
        end
    end

    assign mem_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            if (Stall_F)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (Flush_E)
                r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E;
    logic       RegWrite_E, ResultSrc_E0, PCSrc_E, mem_req_M, mem_ready_M;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic       Stall_F, Stall_D, Stall_E, Stall_M;
    logic       Flush_D, Flush_E, Flush_W, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_ctrl #(.REG_W(5), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .RegWrite_E(RegWrite_E), .ResultSrc_E0(ResultSrc_E0), .PCSrc_E(PCSrc_E),
        .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0; Rd_E = 5'd0;
        RegWrite_E = 1'b0; ResultSrc_E0 = 1'b0; PCSrc_E = 1'b0;
        mem_req_M = 1'b0; mem_ready_M = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    initial begin
        // Reset with hazard-provoking inputs: outputs must still be quiet.
        rst = 1'b1;
        idle();
        mem_req_M = 1'b1; PCSrc_E = 1'b1; ResultSrc_E0 = 1'b1; RegWrite_E = 1'b1;
        Rd_E = 5'd7; Rs1_D = 5'd7; Rs1_E = 5'd7;
        tick(); tick();
        chk1("rst_stallF", Stall_F, 1'b0);
        chk1("rst_stallM", Stall_M, 1'b0);
        chk1("rst_flushD", Flush_D, 1'b0);
        chk1("rst_flushE", Flush_E, 1'b0);
        chk1("rst_flushW", Flush_W, 1'b0);
        chk2("rst_fwdA", ForwardA_E, 2'b00);
        chk1("rst_timeout", mem_timeout, 1'b0);
        idle();
        rst = 1'b0;
        #1;
        chk1("idle_stallF", Stall_F, 1'b0);

        // Back-to-back ALU forwarding of x5: M then W.
        idle(); Rd_E = 5'd5; RegWrite_E = 1'b1;
        tick();
        idle(); Rs2_E = 5'd5; #1;
        chk2("fwdB_M", ForwardB_E, 2'b10);
        chk2("fwdA_none", ForwardA_E, 2'b00);
        tick();
        idle(); Rs2_E = 5'd5; #1;
        chk2("fwdB_W", ForwardB_E, 2'b01);
        tick();
        // x3 in both M and W: M has priority.
        idle(); Rd_E = 5'd3; RegWrite_E = 1'b1; tick();
        idle(); Rd_E = 5'd3; RegWrite_E = 1'b1; tick();
        idle(); Rs1_E = 5'd3; Rs2_E = 5'd3; #1;
        chk2("fwdA_prio", ForwardA_E, 2'b10);
        chk2("fwdB_prio", ForwardB_E, 2'b10);
        tick();

        // x0 writer is never forwarded, from M or from W.
        idle(); Rd_E = 5'd0; RegWrite_E = 1'b1; tick();
        idle(); Rd_E = 5'd0; RegWrite_E = 1'b1; #1;
        chk2("x0_M_A", ForwardA_E, 2'b00);
        chk2("x0_M_B", ForwardB_E, 2'b00);
        tick();
        idle(); #1;
        chk2("x0_W_A", ForwardA_E, 2'b00);
        chk2("x0_W_B", ForwardB_E, 2'b00);
        tick();

        // Load x7 in E with Rs1_D=7: single bubble.
        idle(); ResultSrc_E0 = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd7; Rs1_D = 5'd7; #1;
        chk1("lu_stallF", Stall_F, 1'b1);
        chk1("lu_stallD", Stall_D, 1'b1);
        chk1("lu_flushE", Flush_E, 1'b1);
        chk1("lu_stallE", Stall_E, 1'b0);
        chk1("lu_flushD", Flush_D, 1'b0);
        chk1("lu_flushW", Flush_W, 1'b0);
        tick();
        idle(); Rs1_D = 5'd7; #1;
        chk1("lu_once_stallF", Stall_F, 1'b0);
        chk1("lu_once_flushE", Flush_E, 1'b0);
        tick();
        idle(); Rs1_E = 5'd7; #1;
        chk2("lu_fwdA_W", ForwardA_E, 2'b01);
        // Load into x0 never stalls; Rs2_D match does; non-load never stalls.
        idle(); ResultSrc_E0 = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0; #1;
        chk1("lu_x0_stallF", Stall_F, 1'b0);
        idle(); ResultSrc_E0 = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd4; Rs2_D = 5'd4; #1;
        chk1("lu_rs2_stallD", Stall_D, 1'b1);
        idle(); RegWrite_E = 1'b1; Rd_E = 5'd4; Rs2_D = 5'd4; #1;
        chk1("alu_nostall", Stall_F, 1'b0);
        tick();

        // Three-cycle memory wait; load-use present but suppressed.
        idle(); mem_req_M = 1'b1;
        ResultSrc_E0 = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd7; Rs1_D = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("mw_stallF", Stall_F, 1'b1);
            chk1("mw_stallD", Stall_D, 1'b1);
            chk1("mw_stallE", Stall_E, 1'b1);
            chk1("mw_stallM", Stall_M, 1'b1);
            chk1("mw_flushW", Flush_W, 1'b1);
            chk1("mw_flushE", Flush_E, 1'b0);
            chk1("mw_timeout", mem_timeout, 1'b0);
            tick();
        end
        idle(); mem_req_M = 1'b1; mem_ready_M = 1'b1; #1;
        chk1("mw_done_stallF", Stall_F, 1'b0);
        chk1("mw_done_stallM", Stall_M, 1'b0);
        chk1("mw_done_flushW", Flush_W, 1'b0);
        tick();
        idle(); mem_ready_M = 1'b1; #1;
        chk1("ready_noreq", Stall_M, 1'b0);
        chk1("ready_noreq_to", mem_timeout, 1'b0);
        tick();

        // Six-cycle wait against MAX_WAIT=4: flag visible after 4th edge.
        idle(); mem_req_M = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1("to_low", mem_timeout, 1'b0);
            chk1("to_stallM", Stall_M, 1'b1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            chk1("to_high", mem_timeout, 1'b1);
            chk1("to_stall_cont", Stall_F, 1'b1);
            tick();
        end
        mem_ready_M = 1'b1; #1;
        chk1("to_sticky_ready", mem_timeout, 1'b1);
        chk1("to_unstall", Stall_M, 1'b0);
        tick();
        idle(); #1;
        chk1("to_sticky_run", mem_timeout, 1'b1);
        tick();

        // Branch held during a memory wait flushes once the wait lifts.
        idle(); mem_req_M = 1'b1; PCSrc_E = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk1("br_wait_flushD", Flush_D, 1'b0);
            chk1("br_wait_flushE", Flush_E, 1'b0);
            chk1("br_wait_stallF", Stall_F, 1'b1);
            tick();
        end
        mem_ready_M = 1'b1; #1;
        chk1("br_go_flushD", Flush_D, 1'b1);
        chk1("br_go_flushE", Flush_E, 1'b1);
        chk1("br_go_stallF", Stall_F, 1'b0);
        tick();
        // Branch beats load-use.
        idle(); PCSrc_E = 1'b1; ResultSrc_E0 = 1'b1; RegWrite_E = 1'b1;
        Rd_E = 5'd7; Rs1_D = 5'd7; #1;
        chk1("brlu_stallF", Stall_F, 1'b0);
        chk1("brlu_stallD", Stall_D, 1'b0);
        chk1("brlu_flushD", Flush_D, 1'b1);
        chk1("brlu_flushE", Flush_E, 1'b1);
        tick();

        // Asynchronous reset in the middle of a wait.
        idle(); RegWrite_E = 1'b1; Rd_E = 5'd9; tick();
        idle(); mem_req_M = 1'b1; Rs1_E = 5'd9; #1;
        chk1("rs_pre_stallF", Stall_F, 1'b1);
        chk2("rs_pre_fwdA", ForwardA_E, 2'b10);
        tick();
        chk2("rs_hold_fwdA", ForwardA_E, 2'b10);
        rst = 1'b1; #1;
        chk1("rs_stallF", Stall_F, 1'b0);
        chk1("rs_stallM", Stall_M, 1'b0);
        chk1("rs_flushW", Flush_W, 1'b0);
        chk2("rs_fwdA", ForwardA_E, 2'b00);
        chk1("rs_timeout", mem_timeout, 1'b0);
        #1 rst = 1'b0; #1;
        chk1("rs_post_stallF", Stall_F, 1'b1);
        chk2("rs_post_fwdA", ForwardA_E, 2'b00);
        chk1("rs_post_timeout", mem_timeout, 1'b0);
        tick();
        idle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage RV32I pipeline. Drives ForwardA_E/ForwardB_E select codes into the Execute-stage SrcA/SrcB forwarding muxes, and stall/flush enables into the F/D/E/M/W pipeline registers. Keeps its own shadow scoreboard of Rd/RegWrite for the M and W stages. Sequences multi-cycle data-memory waits, with a watchdog counter.

Parameters:
- REG_W, 5, register-index width
- MAX_WAIT, 16, memory-wait cycles before timeout flags; range 1..255

Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset, asynchronous, active-high
- Rs1_D  input  REG_W  Decode source 1
- Rs2_D  input  REG_W  Decode source 2
- Rs1_E  input  REG_W  Execute source 1
- Rs2_E  input  REG_W  Execute source 2
- Rd_E  input  REG_W  Execute destination
- RegWrite_E  input  1  Execute instruction writes Rd
- ResultSrc_E0  input  1  Execute instruction is a load
- PCSrc_E  input  1  taken branch/jump resolved in Execute
- mem_req_M  input  1  Memory-stage data access in progress
- mem_ready_M  input  1  data memory completes access this cycle
- ForwardA_E  output  2  SrcA select: 00 RD1_E, 01 Result_W, 10 ALUResult_M
- ForwardB_E  output  2  SrcB select, same encoding
- Stall_F  output  1  hold PC
- Stall_D  output  1  hold IF/ID register
- Stall_E  output  1  hold ID/EX register
- Stall_M  output  1  hold EX/MEM register
- Flush_D  output  1  clear IF/ID register
- Flush_E  output  1  clear ID/EX register
- Flush_W  output  1  clear MEM/WB register
- mem_timeout  output  1  sticky: wait exceeded MAX_WAIT

Behaviour:
- Reset (rst=1, async): shadow Rd_M, RegWrite_M, Rd_W, RegWrite_W = 0. State = RUN. wait_cnt = 0. mem_timeout = 0. While rst is high, all stall/flush outputs = 0 and Forward* = 00.
- Forwarding (combinational, per source S in {Rs1_E->A, Rs2_E->B}):
  - 10 if RegWrite_M && Rd_M != 0 && Rd_M == S.
  - Else 01 if RegWrite_W && Rd_W != 0 && Rd_W == S.
  - Else 00. M has priority over W. Code 11 is never driven.
- mem_stall = mem_req_M && !mem_ready_M.
- mem_stall=1:
  - Stall_F = Stall_D = Stall_E = Stall_M = 1.
  - Flush_W = 1.
  - Load-use and branch actions are suppressed that cycle.
- Load-use (mem_stall=0): if ResultSrc_E0 && RegWrite_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D), then Stall_F = Stall_D = 1 and Flush_E = 1 for exactly that cycle. Result: one bubble.
- Branch (mem_stall=0): PCSrc_E=1 gives Flush_D = Flush_E = 1. If PCSrc_E and load-use are both true, branch wins: no stall, both flushes asserted.
- A branch held in E during a mem_stall applies its flush in the first non-stalled cycle.
- Shadow update on posedge clk:
  - If !Stall_M: {Rd_M, RegWrite_M} <= {Rd_E, RegWrite_E}. A same-cycle Flush_E does not affect this capture.
  - If Flush_W: RegWrite_W <= 0, Rd_W <= 0.
  - Else {Rd_W, RegWrite_W} <= {Rd_M, RegWrite_M}.
- FSM:
  - RUN -> WAIT when mem_stall.
  - WAIT -> RUN when !mem_stall.
  - WAIT -> WAIT while mem_stall; wait_cnt increments, saturating at 255.
  - Entering WAIT loads wait_cnt = 1. Returning to RUN clears wait_cnt = 0.
  - wait_cnt reaching MAX_WAIT sets mem_timeout; it clears only on rst.
  - The stall continues regardless of timeout.
- mem_ready_M with mem_req_M=0 is ignored.
- Reset mid-wait returns to RUN with shadow cleared. The next cycle's outputs depend only on the inputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0], both reset to 0, wrapping at 2^32.
  - stall_cycles increments every cycle Stall_F=1.
  - flush_events increments every cycle Flush_E=1.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Back-to-back ALU ops: instruction writes x5 in E, next uses Rs2_E=5 -> ForwardB_E=10 next cycle. Two cycles later, with only W holding x5 -> ForwardB_E=01.
- Rd=x0 writer, with Rs1_E=0 and Rs2_E=0 -> ForwardA_E=00 and ForwardB_E=00 in every stage.
- Load x7 in E, Rs1_D=7 -> Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle. Next cycle ForwardA_E=01 from W.
- mem_req_M=1 with mem_ready_M low for 3 cycles -> Stall_F/D/E/M and Flush_W high for 3 cycles, state WAIT, wait_cnt 1..3. Ready high -> all low, RUN.
- MAX_WAIT=4, ready held low 6 cycles -> mem_timeout rises at 4th wait cycle and stays high after ready; rst clears it.
- PCSrc_E=1 during mem_stall -> no flush. First cycle after ready -> Flush_D=Flush_E=1. Async rst pulse mid-wait -> outputs 0 immediately.
